// File: rtl/sm4_p2s_packer_pkg.sv
// Shared defaults, state encoding and width helpers for the SM4 parallel-to-serial packer.
package sm4_p2s_packer_pkg;

  localparam int BLOCK_WIDTH_DEF = 128;
  localparam int IO_WIDTH_DEF    = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Word-index counter width; never narrower than one bit, even for a single-word block.
  function automatic int cnt_width(input int words);
    int w;
    w = $clog2(words);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sm4_p2s_packer.sv
// Splits 128-bit SM4 result blocks into IO_WIDTH-bit words, MSW first, tagged {sop, eop, word},
// and writes them into the p2s FIFO under its almost-full/full back-pressure.
module sm4_p2s_packer
  import sm4_p2s_packer_pkg::*;
#(
  parameter int BLOCK_WIDTH   = BLOCK_WIDTH_DEF,
  parameter int IO_WIDTH      = IO_WIDTH_DEF,
  parameter int WORDS         = BLOCK_WIDTH / IO_WIDTH,
  parameter int CNT_WIDTH     = cnt_width(WORDS),
  parameter int BLK_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     blk_valid,
  input  logic [BLOCK_WIDTH-1:0]   blk_data,
  output logic                     blk_ready,
  output logic                     fifo_wr_en,
  output logic [IO_WIDTH+1:0]      fifo_in,
  input  logic                     fifo_almost_full,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic [BLK_CNT_WIDTH-1:0] blk_cnt,
  output state_t                   dbg_state
);

  localparam int SOP_BIT = IO_WIDTH + 1;
  localparam int EOP_BIT = IO_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WORDS - 1);

  state_t                 state;
  logic [BLOCK_WIDTH-1:0] sreg;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   eop_word;
  logic                   accept;

  // Handshake: a block transfers on the edge where blk_valid && blk_ready.
  // blk_ready depends only on registered state and the FIFO flags, never on blk_valid.
  assign eop_word   = (cnt == LAST_IDX);
  assign fifo_wr_en = (state == SHIFT) && !fifo_full;
  assign blk_ready  = !fifo_almost_full &&
                      ((state == IDLE) || (eop_word && fifo_wr_en));
  assign accept     = blk_valid && blk_ready;
  assign busy       = (state == SHIFT);
  assign dbg_state  = state;

  always_comb begin
    fifo_in = '0;
    if (state == SHIFT) begin
      fifo_in[SOP_BIT]         = (cnt == '0);
      fifo_in[EOP_BIT]         = eop_word;
      fifo_in[IO_WIDTH-1:0]    = sreg[BLOCK_WIDTH-1 -: IO_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      blk_cnt <= '0;
    end else begin
      if (fifo_wr_en && eop_word) begin
        blk_cnt <= blk_cnt + BLK_CNT_WIDTH'(1);
      end
      // Accept covers both IDLE and the eop cycle, giving back-to-back blocks with no bubble.
      if (accept) begin
        sreg  <= blk_data;
        cnt   <= '0;
        state <= SHIFT;
      end else if (fifo_wr_en) begin
        if (!eop_word) begin
          sreg <= sreg << IO_WIDTH;
          cnt  <= cnt + CNT_WIDTH'(1);
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm4_p2s_packer.sv
// Directed bench for sm4_p2s_packer: default 32-bit words plus a single-word, 4-bit-counter instance.
module tb_sm4_p2s_packer;
  import sm4_p2s_packer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance (4 words/block) ----------------
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic         blk_ready;
  logic         fifo_wr_en;
  logic [33:0]  fifo_in;
  logic         fifo_almost_full = 1'b0;
  logic         fifo_full = 1'b0;
  logic         busy;
  logic [15:0]  blk_cnt;
  state_t       dbg_state;

  sm4_p2s_packer u_dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_in(fifo_in),
    .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
    .busy(busy), .blk_cnt(blk_cnt), .dbg_state(dbg_state)
  );

  // ---------------- single-word instance, 4-bit block counter ----------------
  logic         w_valid = 1'b0;
  logic [127:0] w_data = '0;
  logic         w_ready;
  logic         w_wr_en;
  logic [129:0] w_fifo_in;
  logic         w_busy;
  logic [3:0]   w_blk_cnt;
  state_t       w_state;

  sm4_p2s_packer #(.IO_WIDTH(128), .BLK_CNT_WIDTH(4)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(w_valid), .blk_data(w_data), .blk_ready(w_ready),
    .fifo_wr_en(w_wr_en), .fifo_in(w_fifo_in),
    .fifo_almost_full(1'b0), .fifo_full(1'b0),
    .busy(w_busy), .blk_cnt(w_blk_cnt), .dbg_state(w_state)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [33:0] exp_q[$];

  localparam logic [127:0] BLK_A = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899AABBCCDDEEFF;

  task automatic check_vec(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [127:0] blk);
    exp_q.push_back({2'b10, blk[127:96]});
    exp_q.push_back({2'b00, blk[95:64]});
    exp_q.push_back({2'b00, blk[63:32]});
    exp_q.push_back({2'b01, blk[31:0]});
  endtask

  // Check the word on the FIFO port this cycle against the head of the expected queue.
  task automatic check_word(input string tag);
    logic [33:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;
    check_vec({tag, "_wr_en"}, 160'(fifo_wr_en), 160'(1'b1));
    check_vec({tag, "_word"}, 160'(fifo_in), 160'(e));
  endtask

  function automatic logic [127:0] wide_blk(input int i);
    return {32'(i), 32'hDEADBEEF, ~32'(i), 32'(i * 3)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #2;
    check_vec("rst_ready", 160'(blk_ready), 160'(1'b1));
    check_vec("rst_wr_en", 160'(fifo_wr_en), 160'(1'b0));
    check_vec("rst_fifo_in", 160'(fifo_in), 160'(0));
    check_vec("rst_busy", 160'(busy), 160'(1'b0));
    check_vec("rst_blk_cnt", 160'(blk_cnt), 160'(0));
    step();
    rst_n = 1'b1;
    step();

    // Single block, hand-computed words
    blk_valid = 1'b1;
    blk_data  = BLK_A;
    step();
    blk_valid = 1'b0;
    blk_data  = '0;
    #1;
    check_vec("single_w0", 160'(fifo_in), 160'(34'h2_01234567));
    check_vec("single_wr0", 160'(fifo_wr_en), 160'(1'b1));
    step();
    check_vec("single_w1", 160'(fifo_in), 160'(34'h0_89ABCDEF));
    step();
    check_vec("single_w2", 160'(fifo_in), 160'(34'h0_FEDCBA98));
    step();
    check_vec("single_w3", 160'(fifo_in), 160'(34'h1_76543210));
    step();
    check_vec("single_blk_cnt", 160'(blk_cnt), 160'(1));
    check_vec("single_busy", 160'(busy), 160'(1'b0));
    check_vec("single_idle_wr", 160'(fifo_wr_en), 160'(1'b0));

    // Two blocks back-to-back with blk_valid held high
    push_words(BLK_A);
    push_words(BLK_B);
    blk_valid = 1'b1;
    blk_data  = BLK_A;
    step();
    blk_data  = BLK_B;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_word($sformatf("b2b_%0d", i));
      if (i == 3) check_vec("b2b_ready_eop", 160'(blk_ready), 160'(1'b1));
      if (i == 1) check_vec("b2b_ready_mid", 160'(blk_ready), 160'(1'b0));
      step();
      if (i == 3) blk_valid = 1'b0;
    end
    #1;
    check_vec("b2b_busy", 160'(busy), 160'(1'b0));
    check_vec("b2b_blk_cnt", 160'(blk_cnt), 160'(3));

    // fifo_full for 3 cycles while cnt==1
    push_words(BLK_A);
    blk_valid = 1'b1;
    blk_data  = BLK_A;
    step();
    blk_valid = 1'b0;
    #1;
    check_word("full_w0");
    step();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec($sformatf("full_stall_wr_%0d", i), 160'(fifo_wr_en), 160'(1'b0));
      check_vec($sformatf("full_stall_word_%0d", i), 160'(fifo_in), 160'(34'h0_89ABCDEF));
      step();
    end
    fifo_full = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      check_word($sformatf("full_w%0d", i));
      step();
    end
    #1;
    check_vec("full_blk_cnt", 160'(blk_cnt), 160'(4));

    // almost_full gates acceptance in IDLE
    fifo_almost_full = 1'b1;
    blk_valid = 1'b1;
    blk_data  = BLK_B;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec($sformatf("af_ready_%0d", i), 160'(blk_ready), 160'(1'b0));
      check_vec($sformatf("af_wr_%0d", i), 160'(fifo_wr_en), 160'(1'b0));
      check_vec($sformatf("af_busy_%0d", i), 160'(busy), 160'(1'b0));
      step();
    end
    fifo_almost_full = 1'b0;
    #1;
    check_vec("af_release_ready", 160'(blk_ready), 160'(1'b1));
    push_words(BLK_B);
    step();
    blk_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_word($sformatf("af_w%0d", i));
      step();
    end
    #1;
    check_vec("af_blk_cnt", 160'(blk_cnt), 160'(5));

    // Reset after the second word of a block
    blk_valid = 1'b1;
    blk_data  = BLK_A;
    step();
    blk_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_vec("mrst_wr_en", 160'(fifo_wr_en), 160'(1'b0));
    check_vec("mrst_fifo_in", 160'(fifo_in), 160'(0));
    check_vec("mrst_busy", 160'(busy), 160'(1'b0));
    check_vec("mrst_blk_cnt", 160'(blk_cnt), 160'(0));
    check_vec("mrst_ready", 160'(blk_ready), 160'(1'b1));
    step();
    rst_n = 1'b1;
    step();
    push_words(BLK_B);
    blk_valid = 1'b1;
    blk_data  = BLK_B;
    step();
    blk_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_word($sformatf("post_rst_w%0d", i));
      step();
    end
    #1;
    check_vec("post_rst_blk_cnt", 160'(blk_cnt), 160'(1));

    // Single-word blocks: sop and eop both set, 4-bit counter wraps after 17 blocks
    w_valid = 1'b1;
    w_data  = wide_blk(0);
    step();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) w_data = wide_blk(i + 1);
      else w_valid = 1'b0;
      #1;
      check_vec($sformatf("wide_wr_%0d", i), 160'(w_wr_en), 160'(1'b1));
      check_vec($sformatf("wide_word_%0d", i), 160'(w_fifo_in), 160'({2'b11, wide_blk(i)}));
      step();
    end
    #1;
    check_vec("wide_blk_cnt_wrap", 160'(w_blk_cnt), 160'(1));
    check_vec("wide_busy", 160'(w_busy), 160'(1'b0));

    check_vec("exp_q_drained", 160'(exp_q.size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
